psr_staged: RTL

//  Parametrised two-slot pipeline stage register (left = staging, right = output), with valid tags.

---
 rtl/psr_staged_pkg.sv | 32 +++
 rtl/psr_bubble_ctr.sv | 31 +++
 rtl/psr_staged.sv | 97 +++++++++
 3 files changed

// File: rtl/psr_staged_pkg.sv
// Shared defaults, update-selection enums and field helper for the two-slot
// pipeline stage register.
package psr_staged_pkg;

  localparam int unsigned SIZE_DEF   = 34;
  localparam int unsigned RI_LSB_DEF = 8;
  localparam int unsigned RI_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF  = 2;

  typedef enum logic [1:0] {
    L_HOLD,
    L_RI,
    L_FULL
  } left_op_e;

  typedef enum logic [1:0] {
    R_HOLD,
    R_SHIFT,
    R_DRAIN
  } right_op_e;

  // Bit mask covering [lsb +: w]; callers truncate to their register width.
  function automatic logic [63:0] field_mask(input int unsigned lsb, input int unsigned w);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= lsb && i < lsb + w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/psr_bubble_ctr.sv
// Bubble lockout counter: flush clears, load restarts, decrement stops at zero.
module psr_bubble_ctr #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             nonzero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                    cnt_d = '0;
    else if (load_i)                cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/psr_staged.sv
// Two-slot pipeline stage register (staging -> output) with valid tags,
// bubble lockout, partial Ri-field load and valid-only flush.
module psr_staged
  import psr_staged_pkg::*;
#(
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned RI_LSB = RI_LSB_DEF,
  parameter int unsigned RI_W   = RI_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [SIZE-1:0]  in,
  input  logic             c_left,
  input  logic             c_right,
  input  logic             ld_ri,
  input  logic             bubble,
  input  logic [CNT_W-1:0] bubble_len,
  input  logic             bubble_clr,
  input  logic             flush,
  output logic [SIZE-1:0]  out,
  output logic             out_valid,
  output logic             stg_valid,
  output logic             locked
);

  localparam logic [63:0]     RI_MASK64 = field_mask(RI_LSB, RI_W);
  localparam logic [SIZE-1:0] RI_MASK   = RI_MASK64[SIZE-1:0];

  logic [SIZE-1:0] stg_q;
  logic [SIZE-1:0] out_q;
  logic            stg_vld_q;
  logic            out_vld_q;
  left_op_e        l_op;
  right_op_e       r_op;

  psr_bubble_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk        (clk),
    .clr        (clr),
    .flush_i    (flush),
    .load_i     (bubble & ~flush),
    .load_val_i (bubble_len),
    .dec_i      (bubble_clr),
    .nonzero_o  (locked)
  );

  // Left loads are gated on the pre-edge counter, so loads resume one edge
  // after the counter reaches zero.
  always_comb begin
    l_op = L_HOLD;
    if (!locked) begin
      if (ld_ri)       l_op = L_RI;
      else if (c_left) l_op = L_FULL;
    end
    r_op = R_HOLD;
    if (bubble_clr && locked) r_op = R_DRAIN;
    else if (c_right)         r_op = R_SHIFT;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stg_q     <= '0;
      out_q     <= '0;
      stg_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (flush) begin
      stg_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (bubble) begin
      stg_q     <= '0;
      out_q     <= '0;
      stg_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      case (l_op)
        L_RI: begin
          stg_q     <= (stg_q & ~RI_MASK) | (in & RI_MASK);
          stg_vld_q <= 1'b1;
        end
        L_FULL: begin
          stg_q     <= in;
          stg_vld_q <= 1'b1;
        end
        default: ;
      endcase
      if (r_op == R_SHIFT) begin
        out_q     <= stg_q;
        out_vld_q <= stg_vld_q;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_vld_q;
  assign stg_valid = stg_vld_q;

endmodule
